codec_init_sequencer: RTL and testbench

//  Parametrised codec register-init engine. Holds an N_REGS-entry writable table of {reg_addr, reg_data} frames.
//  On start, streams each frame to the serial (SPI/I2C) master over a valid/ready handshake.

---
 rtl/codec_init_sequencer_if.sv | 35 +++
 rtl/codec_init_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/codec_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : codec_init_sequencer_if
// Description : Frame handshake between the codec init sequencer (master)
//               and the codec serial SPI/I2C master (slave).
//               frame_valid / frame_ready : valid/ready handshake
//               frame_data                : {reg_addr, reg_data} frame
//               frame_idx                 : table index of the presented frame
// Revision    : 1.0 - initial release
// ============================================================================
interface codec_init_sequencer_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 9,
   parameter int IDX_W  = 4
);
   logic                     frame_valid;
   logic [ADDR_W+DATA_W-1:0] frame_data;
   logic                     frame_ready;
   logic [IDX_W-1:0]         frame_idx;

   modport master (
      output frame_valid,
      output frame_data,
      output frame_idx,
      input  frame_ready
   );

   modport slave (
      input  frame_valid,
      input  frame_data,
      input  frame_idx,
      output frame_ready
   );
endinterface
`default_nettype wire

// File: rtl/codec_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : codec_init_sequencer
// Description : Codec register-init engine. Holds an N_REGS-entry table of
//               {reg_addr, reg_data} frames and streams them to the serial
//               master on start. After entry 0 (the codec reset write) it
//               idles SETTLE_CYC cycles before sending the remaining entries.
//               Only the data field of each entry is writable at run time.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start             - 1-cycle pulse, ignored while busy
//               cfg_we/idx/data   - data-field write, only accepted in idle
//               cfg_err           - 1-cycle pulse on a rejected cfg write
//               busy, done        - sequence running / 1-cycle completion
//               frm (master)      - frame_valid/data/idx out, frame_ready in
// Config      : CODEC_INIT_AUTOSTART_EN - when defined, the sequence starts
//               on the first clk edge after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module codec_init_sequencer #(
   parameter int N_REGS     = 11,
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 9,
   parameter int IDX_W      = 4,
   parameter int SETTLE_CYC = 1000,
   // Entry i lives at [i*(ADDR_W+DATA_W) +: ADDR_W+DATA_W]; entry 0 is lowest.
   parameter logic [N_REGS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = {
      16'h1201, 16'h1001, 16'h0E53, 16'h0C00, 16'h0A01, 16'h0810,
      16'h0630, 16'h0430, 16'h0217, 16'h0017, 16'h1E00}
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              start,
   input  wire logic              cfg_we,
   input  wire logic [IDX_W-1:0]  cfg_idx,
   input  wire logic [DATA_W-1:0] cfg_data,
   output logic                   cfg_err,
   output logic                   busy,
   output logic                   done,
   codec_init_sequencer_if.master frm
);

   localparam int c_FRAME_W = ADDR_W + DATA_W;
   localparam int c_CNT_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD =
      c_CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_REGS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEND   = 2'd1,
      S_SETTLE = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_valid;
   logic [c_FRAME_W-1:0] r_frame;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_cfg_err;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [DATA_W-1:0]    r_data [N_REGS];

   logic [ADDR_W-1:0]    w_addr      [N_REGS];
   logic [DATA_W-1:0]    w_init_data [N_REGS];
   logic                 w_start;
   logic                 w_idx_ok;
   logic                 w_cfg_ok;
   logic [IDX_W-1:0]     w_next_idx;
   logic [c_FRAME_W-1:0] w_next_frame;
   logic [c_FRAME_W-1:0] w_first_frame;

   // Address fields are fixed by INIT_TABLE; only data fields are stored.
   for (genvar gi = 0; gi < N_REGS; gi++) begin : g_table
      assign w_addr[gi]      = INIT_TABLE[gi*c_FRAME_W + DATA_W +: ADDR_W];
      assign w_init_data[gi] = INIT_TABLE[gi*c_FRAME_W +: DATA_W];
   end

`ifdef CODEC_INIT_AUTOSTART_EN
   // Set during reset, cleared on the first edge after release: acts as a
   // start pulse on exactly that edge.
   logic r_auto;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_auto <= 1'b1;
      else        r_auto <= 1'b0;
   end
   assign w_start = start | r_auto;
`else
   assign w_start = start;
`endif

   assign w_idx_ok   = ({{(32-IDX_W){1'b0}}, cfg_idx} < N_REGS);
   assign w_cfg_ok   = cfg_we && (r_state == S_IDLE) && w_idx_ok;
   assign w_next_idx = r_idx + 1'b1;

   always_comb begin
      w_next_frame = {w_addr[0], r_data[0]};
      for (int i = 0; i < N_REGS; i++) begin
         if (w_next_idx == IDX_W'(i)) w_next_frame = {w_addr[i], r_data[i]};
      end
   end

   // A cfg write to entry 0 in the same cycle as start must be sent, so
   // bypass the table for the first frame.
   assign w_first_frame = {w_addr[0],
                           (w_cfg_ok && (cfg_idx == '0)) ? cfg_data : r_data[0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_frame   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         r_cnt     <= '0;
         for (int i = 0; i < N_REGS; i++) r_data[i] <= w_init_data[i];
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= cfg_we && !w_cfg_ok;
         for (int i = 0; i < N_REGS; i++) begin
            if (w_cfg_ok && (cfg_idx == IDX_W'(i))) r_data[i] <= cfg_data;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_SEND;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_frame <= w_first_frame;
               end
            end
            S_SEND: begin
               if (r_valid && frm.frame_ready) begin
                  if ((r_idx == '0) && (SETTLE_CYC > 0)) begin
                     r_state <= S_SETTLE;
                     r_cnt   <= c_SETTLE_LOAD;
                     r_valid <= 1'b0;
                  end else if (r_idx == c_LAST) begin
                     // done is raised on entry so it is visible during FIN
                     r_state <= S_FIN;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= w_next_idx;
                     r_frame <= w_next_frame;
                  end
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  if (N_REGS == 1) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_SEND;
                     r_idx   <= w_next_idx;
                     r_frame <= w_next_frame;
                     r_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_idx   <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign frm.frame_valid = r_valid;
   assign frm.frame_data  = r_frame;
   assign frm.frame_idx   = r_idx;
   assign busy            = r_busy;
   assign done            = r_done;
   assign cfg_err         = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_codec_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_codec_init_sequencer
// Description : Directed bench for codec_init_sequencer, SETTLE_CYC = 4,
//               default WM8731 table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codec_init_sequencer;

   localparam logic [15:0] c_DEF [11] = '{
      16'h1E00, 16'h0017, 16'h0217, 16'h0430, 16'h0630, 16'h0810,
      16'h0A01, 16'h0C00, 16'h0E53, 16'h1001, 16'h1201};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       cfg_we;
   logic [3:0] cfg_idx;
   logic [8:0] cfg_data;
   logic       cfg_err;
   logic       busy;
   logic       done;

   codec_init_sequencer_if #(.ADDR_W(7), .DATA_W(9), .IDX_W(4)) bus ();

   codec_init_sequencer #(.SETTLE_CYC(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_data (cfg_data),
      .cfg_err  (cfg_err),
      .busy     (busy),
      .done     (done),
      .frm      (bus)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic [15:0] acc_q [$];
   int          acc_c [$];
   logic [15:0] exp_tab [11];
   int          base_q;
   int          base_d;
   int          stall;
   logic        got;

   // Accepted-frame and done monitor.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && bus.frame_valid && bus.frame_ready) begin
         acc_q.push_back(bus.frame_data);
         acc_c.push_back(cyc);
      end
      if (rst_n && done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done();
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(got), 32'd1);
   endtask

   task automatic check_run(input string tag);
      chk({tag, "_nframes"}, acc_q.size() - base_q, 11);
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("%s_frame%0d", tag, i),
             (base_q + i < acc_q.size()) ? 32'(acc_q[base_q + i]) : 32'hDEAD,
             32'(exp_tab[i]));
      end
      chk({tag, "_ndone"}, done_cnt - base_d, 1);
   endtask

   task automatic mark();
      base_q = acc_q.size();
      base_d = done_cnt;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
      bus.frame_ready = 1'b0;
      for (int i = 0; i < 11; i++) exp_tab[i] = c_DEF[i];

      // Reset state
      tick(); tick();
      chk("rst_valid", 32'(bus.frame_valid), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_err",   32'(cfg_err), 0);
      chk("rst_idx",   32'(bus.frame_idx), 0);
      chk("rst_data",  32'(bus.frame_data), 0);
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("idle_no_autostart", 32'(bus.frame_valid), 0);

      // 1. Full default run, ready always high
      bus.frame_ready = 1'b1;
      mark();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lat_valid", 32'(bus.frame_valid), 1);
      chk("lat_data",  32'(bus.frame_data), 32'h1E00);
      chk("lat_busy",  32'(busy), 1);
      wait_done();
      chk("fin_busy_during_done", 32'(busy), 1);
      tick();
      chk("post_busy", 32'(busy), 0);
      chk("post_done", 32'(done), 0);
      check_run("run1");
      chk("settle_gap", acc_c[base_q + 1] - acc_c[base_q], 5);
      chk("b2b_gap",    acc_c[base_q + 10] - acc_c[base_q + 9], 1);
      chk("done_lat",   done_cyc - acc_c[base_q + 10], 1);

      // 2. Stall 7 cycles on frame 3
      mark();
      stall = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.frame_valid && bus.frame_idx == 4'd3 && stall < 7) begin
            if (stall > 0) begin
               chk("stall_data",  32'(bus.frame_data), 32'h0430);
               chk("stall_valid", 32'(bus.frame_valid), 1);
            end
            bus.frame_ready = 1'b0;
            stall++;
         end else begin
            bus.frame_ready = 1'b1;
         end
         tick();
         if (done) break;
      end
      bus.frame_ready = 1'b1;
      chk("stall_cycles", stall, 7);
      tick();
      check_run("run2");

      // 3. Idle config writes
      cfg_we = 1'b1; cfg_idx = 4'd4; cfg_data = 9'h079;
      tick();
      cfg_we = 1'b0;
      chk("cfg_ok_err", 32'(cfg_err), 0);
      cfg_we = 1'b1; cfg_idx = 4'd11; cfg_data = 9'h1FF;
      tick();
      cfg_we = 1'b0;
      chk("cfg_oor_err", 32'(cfg_err), 1);
      tick();
      chk("cfg_err_pulse", 32'(cfg_err), 0);
      mark();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      tick();
      exp_tab[4] = 16'h0679;
      check_run("run3");

      // 4. Same-cycle cfg+start, cfg and start while busy
      mark();
      cfg_we = 1'b1; cfg_idx = 4'd0; cfg_data = 9'h1AB; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      chk("bypass_err",  32'(cfg_err), 0);
      chk("bypass_data", 32'(bus.frame_data), 32'h1FAB);
      tick();
      cfg_we = 1'b1; cfg_idx = 4'd5; cfg_data = 9'h0FF; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      chk("busy_cfg_err", 32'(cfg_err), 1);
      wait_done();
      tick();
      exp_tab[0] = 16'h1FAB;
      check_run("run4");
      tick(); tick(); tick();
      chk("no_queued_start", 32'(bus.frame_valid), 0);
      chk("no_queued_busy",  32'(busy), 0);

      // 5. Reset during SETTLE
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(bus.frame_valid), 0);
      chk("abort_busy",  32'(busy), 0);
      chk("abort_idx",   32'(bus.frame_idx), 0);
      chk("abort_data",  32'(bus.frame_data), 0);
      tick();
      rst_n = 1'b1;
      tick();
      mark();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_data", 32'(bus.frame_data), 32'h1E00);
      wait_done();
      tick();
      for (int i = 0; i < 11; i++) exp_tab[i] = c_DEF[i];
      check_run("run5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
